// File: rtl/auth_tag_checker.sv
// auth_tag_checker
// Captures the locally computed authentication tag and the peer's tag (which
// arrives MSB-first as a byte stream), compares them, and reports pass, fail or
// timeout as one-cycle pulses and as sticky status. Single clock domain; start
// must already be synchronised to clk.

module auth_tag_checker #(
    parameter int TAG_WIDTH      = 40,
    parameter int TIMEOUT_CYCLES = 12500000,
    parameter int TIMER_WIDTH    = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [TAG_WIDTH-1:0] local_tag,
    input  logic                 local_tag_valid,
    input  logic [7:0]           peer_byte,
    input  logic                 peer_byte_valid,
    output logic                 busy,
    output logic                 auth_pass,
    output logic                 auth_fail,
    output logic                 auth_timeout,
    output logic [2:0]           status,
    output logic                 peer_overrun,
    output logic [TAG_WIDTH-1:0] local_tag_q,
    output logic [TAG_WIDTH-1:0] peer_tag_q
);

    localparam int TAG_BYTES   = TAG_WIDTH / 8;
    localparam int COUNT_WIDTH = $clog2(TAG_BYTES + 1);

    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(TAG_BYTES);
    localparam logic [COUNT_WIDTH-1:0] LAST_BYTE  = COUNT_WIDTH'(TAG_BYTES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = TIMER_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COMPARE
    } state_t;

    state_t                 state;
    logic                   have_local;
    logic                   have_peer;
    logic [COUNT_WIDTH-1:0] byte_count;
    logic [TIMER_WIDTH-1:0] timer;

    logic local_take;
    logic peer_room;
    logic peer_take;
    logic tags_complete_next;

    // Decide what this cycle may capture, and whether both tags will be held
    // after this edge (a completion on the final timer cycle beats the timeout).
    always_comb begin
        local_take         = 1'b0;
        peer_room          = 1'b0;
        peer_take          = 1'b0;
        tags_complete_next = 1'b0;

        local_take         = local_tag_valid && !have_local;
        peer_room          = (byte_count < FULL_COUNT);
        peer_take          = peer_byte_valid && peer_room;
        tags_complete_next = (have_local || local_take) &&
                             (have_peer || (peer_take && (byte_count == LAST_BYTE)));
    end

    // Control FSM with tag capture, timeout timer and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            have_local   <= 1'b0;
            have_peer    <= 1'b0;
            byte_count   <= '0;
            timer        <= '0;
            busy         <= 1'b0;
            auth_pass    <= 1'b0;
            auth_fail    <= 1'b0;
            auth_timeout <= 1'b0;
            status       <= 3'b000;
            peer_overrun <= 1'b0;
            local_tag_q  <= '0;
            peer_tag_q   <= '0;
        end else begin
            auth_pass    <= 1'b0;
            auth_fail    <= 1'b0;
            auth_timeout <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_ARMED;
                        busy         <= 1'b1;
                        have_local   <= 1'b0;
                        have_peer    <= 1'b0;
                        byte_count   <= '0;
                        timer        <= '0;
                        status       <= 3'b000;
                        peer_overrun <= 1'b0;
                        local_tag_q  <= '0;
                        peer_tag_q   <= '0;
                    end
                end

                ST_ARMED: begin
                    if (start) begin
                        have_local   <= 1'b0;
                        have_peer    <= 1'b0;
                        byte_count   <= '0;
                        timer        <= '0;
                        status       <= 3'b000;
                        peer_overrun <= 1'b0;
                        local_tag_q  <= '0;
                        peer_tag_q   <= '0;
                    end else begin
                        timer <= timer + TIMER_ONE;

                        if (local_take) begin
                            local_tag_q <= local_tag;
                            have_local  <= 1'b1;
                        end

                        if (peer_take) begin
                            peer_tag_q <= {peer_tag_q[TAG_WIDTH-9:0], peer_byte};
                            byte_count <= byte_count + COUNT_ONE;
                            if (byte_count == LAST_BYTE) begin
                                have_peer <= 1'b1;
                            end
                        end else if (peer_byte_valid) begin
                            peer_overrun <= 1'b1;
                        end

                        if (have_local && have_peer) begin
                            state <= ST_COMPARE;
                        end else if ((timer == TIMER_LAST) && !tags_complete_next) begin
                            state        <= ST_IDLE;
                            busy         <= 1'b0;
                            auth_timeout <= 1'b1;
                            status[2]    <= 1'b1;
                        end
                    end
                end

                ST_COMPARE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (local_tag_q == peer_tag_q) begin
                        auth_pass <= 1'b1;
                        status[0] <= 1'b1;
                    end else begin
                        auth_fail <= 1'b1;
                        status[1] <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_auth_tag_checker.sv
// tb_auth_tag_checker
// Directed scenarios plus randomized traffic for auth_tag_checker, checked every
// cycle against a timestamp-based reference model of the tag checker.

module tb_auth_tag_checker;

    localparam int TAG_WIDTH = 40;
    localparam int T         = 16;
    localparam int NBYTES    = TAG_WIDTH / 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [TAG_WIDTH-1:0] local_tag = '0;
    logic                 local_tag_valid = 1'b0;
    logic [7:0]           peer_byte = '0;
    logic                 peer_byte_valid = 1'b0;
    logic                 busy;
    logic                 auth_pass;
    logic                 auth_fail;
    logic                 auth_timeout;
    logic [2:0]           status;
    logic                 peer_overrun;
    logic [TAG_WIDTH-1:0] local_tag_q;
    logic [TAG_WIDTH-1:0] peer_tag_q;

    auth_tag_checker #(
        .TAG_WIDTH      (TAG_WIDTH),
        .TIMEOUT_CYCLES (T),
        .TIMER_WIDTH    (24)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .local_tag       (local_tag),
        .local_tag_valid (local_tag_valid),
        .peer_byte       (peer_byte),
        .peer_byte_valid (peer_byte_valid),
        .busy            (busy),
        .auth_pass       (auth_pass),
        .auth_fail       (auth_fail),
        .auth_timeout    (auth_timeout),
        .status          (status),
        .peer_overrun    (peer_overrun),
        .local_tag_q     (local_tag_q),
        .peer_tag_q      (peer_tag_q)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model: an arm is tracked by the edge it started on, the tags
    // collected so far, and the edge on which the last tag arrived.
    int                   edge_n = 0;
    bit                   m_active;
    bit                   m_cmp;
    int                   m_arm_edge;
    bit                   m_lhave;
    logic [TAG_WIDTH-1:0] m_lval;
    logic [7:0]           m_peer[$];
    int                   m_done_edge;
    bit                   m_ovr;
    logic [2:0]           m_status;
    bit                   m_pass;
    bit                   m_fail;
    bit                   m_to;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [TAG_WIDTH-1:0] model_peer_value();
        logic [TAG_WIDTH-1:0] v;
        v = '0;
        foreach (m_peer[i]) v = (v << 8) | TAG_WIDTH'(m_peer[i]);
        return v;
    endfunction

    task automatic model_arm(input bit active);
        m_active    = active;
        m_cmp       = 1'b0;
        m_arm_edge  = edge_n;
        m_lhave     = 1'b0;
        m_lval      = '0;
        m_peer.delete();
        m_done_edge = -1;
        m_ovr       = 1'b0;
        m_status    = 3'b000;
    endtask

    task automatic model_capture();
        if (local_tag_valid && !m_lhave) begin
            m_lhave = 1'b1;
            m_lval  = local_tag;
        end
        if (peer_byte_valid) begin
            if (m_peer.size() < NBYTES) m_peer.push_back(peer_byte);
            else                        m_ovr = 1'b1;
        end
    endtask

    // Advance the model on every rising edge using the inputs the DUT samples.
    always @(posedge clk) begin
        bit tags_were_complete;
        edge_n++;
        m_pass = 1'b0;
        m_fail = 1'b0;
        m_to   = 1'b0;
        if (reset) begin
            model_arm(1'b0);
        end else if (m_cmp) begin
            m_cmp    = 1'b0;
            m_active = 1'b0;
            if (m_lval == model_peer_value()) begin
                m_pass   = 1'b1;
                m_status = 3'b001;
            end else begin
                m_fail   = 1'b1;
                m_status = 3'b010;
            end
        end else if (m_active) begin
            if (start) begin
                model_arm(1'b1);
            end else begin
                tags_were_complete = (m_done_edge >= 0);
                model_capture();
                if (tags_were_complete) begin
                    m_cmp = 1'b1;
                end else if ((edge_n - m_arm_edge == T) &&
                             !(m_lhave && m_peer.size() == NBYTES)) begin
                    m_active = 1'b0;
                    m_to     = 1'b1;
                    m_status = 3'b100;
                end
                if (m_done_edge < 0 && m_lhave && m_peer.size() == NBYTES)
                    m_done_edge = edge_n;
            end
        end else if (start) begin
            model_arm(1'b1);
        end
    end

    // Compare every DUT output with the model on each falling edge.
    always @(negedge clk) begin
        if (check_en && !reset) begin
            check_output("busy",         busy,         m_active || m_cmp);
            check_output("auth_pass",    auth_pass,    m_pass);
            check_output("auth_fail",    auth_fail,    m_fail);
            check_output("auth_timeout", auth_timeout, m_to);
            check_output("status",       status,       m_status);
            check_output("peer_overrun", peer_overrun, m_ovr);
            check_output("local_tag_q",  local_tag_q,  m_lval);
            check_output("peer_tag_q",   peer_tag_q,   model_peer_value());
        end
    end

    // Drive one cycle of inputs, consumed by the next rising edge.
    task automatic apply_stimulus(input bit s, input bit lv, input logic [TAG_WIDTH-1:0] lt,
                                  input bit pv, input logic [7:0] pb);
        @(negedge clk);
        #2;
        start           = s;
        local_tag_valid = lv;
        local_tag       = lt;
        peer_byte_valid = pv;
        peer_byte       = pb;
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, 8'h00);
    endtask

    // Wait for the edge that consumes the last applied inputs, then settle.
    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    // Arm, local tag at offset 3, peer bytes at offsets 5..9, idle at offset 10.
    task automatic collect_tags(input logic [7:0] last_byte);
        logic [7:0] bytes [5];
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
        bytes[4] = last_byte;
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 8'h00);
        apply_idle();
        apply_idle();
        apply_stimulus(1'b0, 1'b1, 40'h12_3456_789A, 1'b0, 8'h00);
        apply_idle();
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, '0, 1'b1, bytes[i]);
        apply_idle();
        step_edge();
        check_output("pre_result_busy", busy, 1'b1);
        check_output("pre_result_pulses", {auth_pass, auth_fail, auth_timeout}, 3'b000);
    endtask

    initial begin
        logic [TAG_WIDTH-1:0] tgt;
        logic [TAG_WIDTH-1:0] sh;
        int pidx;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_status", status, 3'b000);
        check_output("rst_tags", {local_tag_q, peer_tag_q}, 80'h0);
        @(negedge clk);
        #2;
        reset    = 1'b0;
        check_en = 1'b1;
        apply_idle();

        // Matching tags: pass at offset 11.
        collect_tags(8'h9A);
        apply_idle();
        step_edge();
        check_output("t1_pass", auth_pass, 1'b1);
        check_output("t1_status", status, 3'b001);
        check_output("t1_busy", busy, 1'b0);
        apply_idle();
        step_edge();
        check_output("t1_pass_single", auth_pass, 1'b0);

        // Last peer byte differs: fail.
        collect_tags(8'h9B);
        apply_idle();
        step_edge();
        check_output("t2_fail", auth_fail, 1'b1);
        check_output("t2_pass", auth_pass, 1'b0);
        check_output("t2_status", status, 3'b010);
        check_output("t2_peer_tag_q", peer_tag_q, 40'h12_3456_789B);
        apply_idle();

        // Only local tag: timeout T cycles after arm.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b1, 40'hAA_BBCC_DDEE, 1'b0, 8'h00);
        for (int k = 2; k < T; k++) apply_idle();
        step_edge();
        check_output("t3_no_early_timeout", auth_timeout, 1'b0);
        apply_idle();
        step_edge();
        check_output("t3_timeout", auth_timeout, 1'b1);
        check_output("t3_status", status, 3'b100);
        check_output("t3_busy", busy, 1'b0);
        apply_idle();

        // Completion on the final timer cycle: compare beats timeout.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h12);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h34);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h56);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h78);
        for (int k = 5; k < T; k++) apply_idle();
        apply_stimulus(1'b0, 1'b1, 40'h12_3456_789A, 1'b1, 8'h9A);
        step_edge();
        check_output("t4_no_timeout", auth_timeout, 1'b0);
        check_output("t4_busy", busy, 1'b1);
        apply_idle();
        apply_idle();
        step_edge();
        check_output("t4_pass", auth_pass, 1'b1);
        check_output("t4_status", status, 3'b001);
        apply_idle();

        // Six peer bytes: overrun, sixth byte dropped, still a pass.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b1, 40'h12_3456_789A, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h12);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h34);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h56);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h78);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h9A);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'hFF);
        step_edge();
        check_output("t5_overrun", peer_overrun, 1'b1);
        check_output("t5_peer_tag_q", peer_tag_q, 40'h12_3456_789A);
        apply_idle();
        step_edge();
        check_output("t5_pass", auth_pass, 1'b1);
        apply_idle();

        // Reset mid-collection, then stray inputs in IDLE.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b1, 40'h12_3456_789A, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'h12);
        step_edge();
        check_output("t6_busy_before_reset", busy, 1'b1);
        start = 1'b0; local_tag_valid = 1'b0; peer_byte_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_output("t6_async_busy", busy, 1'b0);
        check_output("t6_async_flags", {auth_pass, auth_fail, auth_timeout, status, peer_overrun}, 7'h0);
        check_output("t6_async_local", local_tag_q, 40'h0);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 6; k++)
            apply_stimulus(1'b0, 1'b1, 40'({$urandom(), $urandom()}), 1'b1, 8'($urandom()));
        apply_idle();
        step_edge();
        check_output("t6_idle_status", status, 3'b000);
        check_output("t6_idle_local", local_tag_q, 40'h0);
        check_output("t6_idle_busy", busy, 1'b0);

        // Randomized traffic against the model.
        tgt  = 40'({$urandom(), $urandom()});
        pidx = 0;
        repeat (4000) begin
            bit                   s;
            bit                   lv;
            bit                   pv;
            logic [TAG_WIDTH-1:0] lt;
            logic [7:0]           pb;
            s = ($urandom_range(0, 39) == 0);
            if (s) begin
                tgt  = 40'({$urandom(), $urandom()});
                pidx = 0;
            end
            lv = ($urandom_range(0, 5) == 0);
            lt = ($urandom_range(0, 7) == 0) ? 40'({$urandom(), $urandom()}) : tgt;
            pv = ($urandom_range(0, 1) == 0);
            if (pidx < NBYTES) begin
                sh = tgt >> (8 * (NBYTES - 1 - pidx));
                pb = sh[7:0];
            end else begin
                pb = 8'($urandom());
            end
            if ($urandom_range(0, 11) == 0) pb = pb ^ 8'h01;
            if (pv) pidx++;
            apply_stimulus(s, lv, lt, pv, pb);
        end
        repeat (4) apply_idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
